// File: rtl/camera_mode_sequencer.sv
// rtl/camera_mode_sequencer.sv - camera sensor power-up, ID check and mode configuration sequencer over an I2C command port
// Optional sensor ID verification is enabled by defining CAMERA_ID_CHECK_EN.
module camera_mode_sequencer #(
    parameter int POWER_UP_CYCLES = 48000
) (
    input  logic        clk_in,
    input  logic        reset_n,
    input  logic [1:0]  mode,
    input  logic [1:0]  resolution,
    input  logic        format,
    output logic        ready,
    output logic        power_enable,
    output logic        model_err,
    output logic        nack_err,
    output logic        cmd_valid,
    input  logic        cmd_ready,
    output logic        cmd_read,
    output logic [15:0] cmd_addr,
    output logic [7:0]  cmd_wdata,
    input  logic        done,
    input  logic        done_nack,
    input  logic [7:0]  done_rdata
);

    typedef enum logic [2:0] {
        S_OFF,
        S_POWER_WAIT,
        S_ID_HI,
        S_ID_LO,
        S_CONFIG,
        S_STREAM_ON,
        S_IDLE,
        S_ERROR
    } state_t;

    localparam int CNT_W = (POWER_UP_CYCLES > 1) ? $clog2(POWER_UP_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(POWER_UP_CYCLES - 1);
    localparam logic [2:0] LAST_STEP = 3'd6;
    localparam logic [15:0] SENSOR_ID = 16'h0219;

    state_t           state, state_next;
    logic [CNT_W-1:0] cnt_q;
    logic [2:0]       step_q;
    logic             outstanding_q;
    logic [1:0]       mode_q;
    logic [1:0]       res_q;
    logic             fmt_q;
    logic [7:0]       id_hi_q;
    logic             power_enable_q;
    logic             nack_err_q;

    logic [1:0]       norm_mode;
    logic             inputs_changed;
    logic             cmd_state;
    logic             complete;
    logic             id_mismatch;
    logic [15:0]      width;
    logic [15:0]      height;
    logic [7:0]       fmt_byte;

    logic             latch_inputs;
    logic             set_pe;
    logic             clr_pe;
    logic             set_nack;
    logic             clr_err;
    logic             step_inc;

    // Mode 3 behaves exactly like standby, so it is folded before latching and comparing.
    assign norm_mode      = (mode == 2'd3) ? 2'd1 : mode;
    assign inputs_changed = ({norm_mode, resolution, format} != {mode_q, res_q, fmt_q});
    assign cmd_state      = (state == S_ID_HI) || (state == S_ID_LO) ||
                            (state == S_CONFIG) || (state == S_STREAM_ON);
    assign complete       = done && outstanding_q && cmd_state;
    assign id_mismatch    = ({id_hi_q, done_rdata} != SENSOR_ID);
    assign fmt_byte       = fmt_q ? 8'h0A : 8'h08;

    assign ready          = ((state == S_OFF) && (norm_mode == 2'd0)) ||
                            ((state == S_IDLE) && !inputs_changed);
    assign power_enable   = power_enable_q;
    assign nack_err       = nack_err_q;

    always_comb begin
        width  = 16'h0CD0;
        height = 16'h09A0;
        case (res_q)
            2'd0: begin width = 16'h0CD0; height = 16'h09A0; end
            2'd1: begin width = 16'h0780; height = 16'h0438; end
            2'd2: begin width = 16'h0668; height = 16'h04D0; end
            2'd3: begin width = 16'h0280; height = 16'h01E0; end
            default: begin width = 16'h0CD0; height = 16'h09A0; end
        endcase
    end

`ifdef CAMERA_ID_CHECK_EN
    logic model_err_q;
    logic set_model;
    assign model_err = model_err_q;
`else
    assign model_err = 1'b0;
`endif

    always_comb begin
        state_next   = state;
        latch_inputs = 1'b0;
        set_pe       = 1'b0;
        clr_pe       = 1'b0;
        set_nack     = 1'b0;
        clr_err      = 1'b0;
        step_inc     = 1'b0;
`ifdef CAMERA_ID_CHECK_EN
        set_model    = 1'b0;
`endif
        case (state)
            S_OFF: begin
                if (norm_mode != 2'd0) begin
                    latch_inputs = 1'b1;
                    set_pe       = 1'b1;
                    state_next   = S_POWER_WAIT;
                end
            end
            S_POWER_WAIT: begin
                if (cnt_q == CNT_LAST) begin
`ifdef CAMERA_ID_CHECK_EN
                    state_next = S_ID_HI;
`else
                    state_next = S_CONFIG;
`endif
                end
            end
            S_ID_HI: begin
                if (complete) begin
                    if (done_nack) begin
                        set_nack   = 1'b1;
                        state_next = S_ERROR;
                    end else begin
                        state_next = S_ID_LO;
                    end
                end
            end
            S_ID_LO: begin
                if (complete) begin
                    if (done_nack) begin
                        set_nack   = 1'b1;
                        state_next = S_ERROR;
                    end else if (id_mismatch) begin
`ifdef CAMERA_ID_CHECK_EN
                        set_model  = 1'b1;
`endif
                        state_next = S_ERROR;
                    end else begin
                        state_next = S_CONFIG;
                    end
                end
            end
            S_CONFIG: begin
                if (complete) begin
                    if (done_nack) begin
                        set_nack   = 1'b1;
                        state_next = S_ERROR;
                    end else if (step_q == LAST_STEP) begin
                        state_next = (mode_q == 2'd2) ? S_STREAM_ON : S_IDLE;
                    end else begin
                        step_inc = 1'b1;
                    end
                end
            end
            S_STREAM_ON: begin
                if (complete) begin
                    if (done_nack) begin
                        set_nack   = 1'b1;
                        state_next = S_ERROR;
                    end else begin
                        state_next = S_IDLE;
                    end
                end
            end
            S_IDLE: begin
                if (inputs_changed) begin
                    latch_inputs = 1'b1;
                    if (norm_mode == 2'd0) begin
                        clr_pe     = 1'b1;
                        state_next = S_OFF;
                    end else begin
                        state_next = S_CONFIG;
                    end
                end
            end
            S_ERROR: begin
                if (mode == 2'd0) begin
                    clr_err    = 1'b1;
                    state_next = S_OFF;
                end
            end
            default: state_next = S_OFF;
        endcase
    end

    // Command fields are decoded from state/step so they stay stable while cmd_valid is high.
    always_comb begin
        cmd_valid = cmd_state && !outstanding_q;
        cmd_read  = 1'b0;
        cmd_addr  = 16'h0000;
        cmd_wdata = 8'h00;
        case (state)
            S_ID_HI: begin
`ifdef CAMERA_ID_CHECK_EN
                cmd_read = 1'b1;
`endif
                cmd_addr = 16'h0000;
            end
            S_ID_LO: begin
`ifdef CAMERA_ID_CHECK_EN
                cmd_read = 1'b1;
`endif
                cmd_addr = 16'h0001;
            end
            S_CONFIG: begin
                case (step_q)
                    3'd0: begin cmd_addr = 16'h0100; cmd_wdata = 8'h00;         end
                    3'd1: begin cmd_addr = 16'h016C; cmd_wdata = width[15:8];  end
                    3'd2: begin cmd_addr = 16'h016D; cmd_wdata = width[7:0];   end
                    3'd3: begin cmd_addr = 16'h016E; cmd_wdata = height[15:8]; end
                    3'd4: begin cmd_addr = 16'h016F; cmd_wdata = height[7:0];  end
                    3'd5: begin cmd_addr = 16'h018C; cmd_wdata = fmt_byte;     end
                    3'd6: begin cmd_addr = 16'h018D; cmd_wdata = fmt_byte;     end
                    default: begin cmd_addr = 16'h0000; cmd_wdata = 8'h00;     end
                endcase
            end
            S_STREAM_ON: begin
                cmd_addr  = 16'h0100;
                cmd_wdata = 8'h01;
            end
            default: begin
                cmd_addr  = 16'h0000;
                cmd_wdata = 8'h00;
            end
        endcase
    end

    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            state          <= S_OFF;
            cnt_q          <= '0;
            step_q         <= 3'd0;
            outstanding_q  <= 1'b0;
            mode_q         <= 2'd0;
            res_q          <= 2'd0;
            fmt_q          <= 1'b0;
            id_hi_q        <= 8'h00;
            power_enable_q <= 1'b0;
            nack_err_q     <= 1'b0;
        end else begin
            state <= state_next;

            if ((state == S_POWER_WAIT) && (state_next == S_POWER_WAIT)) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end else begin
                cnt_q <= '0;
            end

            if (state_next != S_CONFIG) begin
                step_q <= 3'd0;
            end else if (step_inc) begin
                step_q <= step_q + 3'd1;
            end

            // Any state change or completion retires the outstanding command.
            if (complete || (state_next != state)) begin
                outstanding_q <= 1'b0;
            end else if (cmd_valid && cmd_ready) begin
                outstanding_q <= 1'b1;
            end

            if (latch_inputs) begin
                mode_q <= norm_mode;
                res_q  <= resolution;
                fmt_q  <= format;
            end

            if (complete && (state == S_ID_HI)) begin
                id_hi_q <= done_rdata;
            end

            if (clr_pe || (state_next == S_ERROR)) begin
                power_enable_q <= 1'b0;
            end else if (set_pe) begin
                power_enable_q <= 1'b1;
            end

            if (clr_err) begin
                nack_err_q <= 1'b0;
            end else if (set_nack) begin
                nack_err_q <= 1'b1;
            end
        end
    end

`ifdef CAMERA_ID_CHECK_EN
    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            model_err_q <= 1'b0;
        end else if (clr_err) begin
            model_err_q <= 1'b0;
        end else if (set_model) begin
            model_err_q <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_camera_mode_sequencer.sv
// tb/tb_camera_mode_sequencer.sv - self-checking bench for camera_mode_sequencer with a responding I2C master model
module tb_camera_mode_sequencer;

    logic        clk_in;
    logic        reset_n;
    logic [1:0]  mode;
    logic [1:0]  resolution;
    logic        format;
    logic        ready;
    logic        power_enable;
    logic        model_err;
    logic        nack_err;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_read;
    logic [15:0] cmd_addr;
    logic [7:0]  cmd_wdata;
    logic        done;
    logic        done_nack;
    logic [7:0]  done_rdata;

    camera_mode_sequencer #(.POWER_UP_CYCLES(16)) dut (
        .clk_in       (clk_in),
        .reset_n      (reset_n),
        .mode         (mode),
        .resolution   (resolution),
        .format       (format),
        .ready        (ready),
        .power_enable (power_enable),
        .model_err    (model_err),
        .nack_err     (nack_err),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_read     (cmd_read),
        .cmd_addr     (cmd_addr),
        .cmd_wdata    (cmd_wdata),
        .done         (done),
        .done_nack    (done_nack),
        .done_rdata   (done_rdata)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    int tests_run = 0;
    int tests_failed = 0;

    logic [24:0] log_q[$];
    logic [24:0] exp_q[$];
    logic [15:0] nack_addr = 16'hFFFF;
    logic [7:0]  id_hi_val = 8'h02;
    logic [7:0]  id_lo_val = 8'h19;
    int          force_req = 0;

    // I2C master model: logs each accepted command and answers with done two cycles later.
    initial begin : master_model
        logic       busy;
        int         dly;
        int         force_ack;
        logic       pend_nack;
        logic [7:0] pend_rdata;
        busy = 1'b0; dly = 0; force_ack = 0; pend_nack = 1'b0; pend_rdata = 8'h00;
        done = 1'b0; done_nack = 1'b0; done_rdata = 8'h00;
        forever begin
            @(negedge clk_in);
            done      = 1'b0;
            done_nack = 1'b0;
            if (force_req != force_ack) begin
                force_ack = force_req;
                done      = 1'b1;
            end else if (busy) begin
                if (dly == 0) begin
                    done       = 1'b1;
                    done_nack  = pend_nack;
                    done_rdata = pend_rdata;
                    busy       = 1'b0;
                end else begin
                    dly = dly - 1;
                end
            end else if (cmd_valid && cmd_ready) begin
                log_q.push_back({cmd_read, cmd_addr, cmd_wdata});
                busy       = 1'b1;
                dly        = 1;
                pend_nack  = !cmd_read && (cmd_addr == nack_addr);
                pend_rdata = (cmd_addr == 16'h0000) ? id_hi_val : id_lo_val;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_ready(input int budget, input string name);
        int n;
        n = 0;
        while (ready !== 1'b1 && n < budget) begin
            @(negedge clk_in);
            n++;
        end
        if (ready !== 1'b1) begin
            tests_run++;
            tests_failed++;
            $display("FAIL %s_timeout: ready still %0b after %0d cycles, expected 1", name, ready, budget);
        end
    endtask

    task automatic add_wr(input logic [15:0] a, input logic [7:0] d);
        exp_q.push_back({1'b0, a, d});
    endtask

    task automatic add_reads();
`ifdef CAMERA_ID_CHECK_EN
        exp_q.push_back({1'b1, 16'h0000, 8'h00});
        exp_q.push_back({1'b1, 16'h0001, 8'h00});
`endif
    endtask

    task automatic add_cfg(input logic [15:0] w, input logic [15:0] h, input logic [7:0] fb, input logic stream);
        add_wr(16'h0100, 8'h00);
        add_wr(16'h016C, w[15:8]);
        add_wr(16'h016D, w[7:0]);
        add_wr(16'h016E, h[15:8]);
        add_wr(16'h016F, h[7:0]);
        add_wr(16'h018C, fb);
        add_wr(16'h018D, fb);
        if (stream) add_wr(16'h0100, 8'h01);
    endtask

    task automatic compare_log(input string name, input int base);
        int n;
        n = log_q.size() - base;
        chk({name, "_count"}, 32'(n), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            if (base + i < log_q.size())
                chk($sformatf("%s_cmd%0d", name, i), 32'(log_q[base + i]), 32'(exp_q[i]));
        end
    endtask

    task automatic chk_reset_outputs(input string name);
        chk({name, "_ready"},     32'(ready),        32'd1);
        chk({name, "_pwr"},       32'(power_enable), 32'd0);
        chk({name, "_cmd_valid"}, 32'(cmd_valid),    32'd0);
        chk({name, "_cmd_read"},  32'(cmd_read),     32'd0);
        chk({name, "_cmd_addr"},  32'(cmd_addr),     32'd0);
        chk({name, "_cmd_wdata"}, 32'(cmd_wdata),    32'd0);
        chk({name, "_model_err"}, 32'(model_err),    32'd0);
        chk({name, "_nack_err"},  32'(nack_err),     32'd0);
    endtask

    typedef struct {
        logic [1:0]  mode;
        logic [1:0]  res;
        logic        fmt;
        logic        powerup;
        logic        cfg;
        logic [15:0] w;
        logic [15:0] h;
        logic [7:0]  fb;
        logic        stream;
        logic        exp_pe;
    } vec_t;

    vec_t vecs[7];

    initial begin : main
        int base;
        int k;
        vec_t v;

        vecs[0] = '{2'd2, 2'd1, 1'b1, 1'b1, 1'b1, 16'h0780, 16'h0438, 8'h0A, 1'b1, 1'b1};
        vecs[1] = '{2'd1, 2'd3, 1'b0, 1'b0, 1'b1, 16'h0280, 16'h01E0, 8'h08, 1'b0, 1'b1};
        vecs[2] = '{2'd1, 2'd0, 1'b0, 1'b0, 1'b1, 16'h0CD0, 16'h09A0, 8'h08, 1'b0, 1'b1};
        vecs[3] = '{2'd3, 2'd2, 1'b1, 1'b0, 1'b1, 16'h0668, 16'h04D0, 8'h0A, 1'b0, 1'b1};
        vecs[4] = '{2'd2, 2'd2, 1'b1, 1'b0, 1'b1, 16'h0668, 16'h04D0, 8'h0A, 1'b1, 1'b1};
        vecs[5] = '{2'd0, 2'd2, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 8'h00, 1'b0, 1'b0};
        vecs[6] = '{2'd2, 2'd0, 1'b0, 1'b1, 1'b1, 16'h0CD0, 16'h09A0, 8'h08, 1'b1, 1'b1};

        reset_n = 1'b0; mode = 2'd0; resolution = 2'd0; format = 1'b0; cmd_ready = 1'b1;
        repeat (3) @(negedge clk_in);
        chk_reset_outputs("reset_hold");
        reset_n = 1'b1;
        @(negedge clk_in);
        chk_reset_outputs("reset_release");

        for (int i = 0; i < 7; i++) begin
            v = vecs[i];
            @(negedge clk_in);
            base = log_q.size();
            exp_q.delete();
            if (v.powerup) add_reads();
            if (v.cfg) add_cfg(v.w, v.h, v.fb, v.stream);
            mode = v.mode; resolution = v.res; format = v.fmt;
            #1;
            chk($sformatf("vec%0d_ready_drop", i), 32'(ready), 32'd0);
            if (v.powerup) begin
                k = 0;
                while (!power_enable && k < 5) begin @(negedge clk_in); k++; end
                chk($sformatf("vec%0d_pwr_rise", i), 32'(power_enable), 32'd1);
                k = 0;
                while (!cmd_valid && k < 100) begin @(negedge clk_in); k++; end
                chk($sformatf("vec%0d_pwr_wait", i), 32'(k), 32'd16);
            end
            wait_ready(2000, $sformatf("vec%0d", i));
            compare_log($sformatf("vec%0d", i), base);
            chk($sformatf("vec%0d_pwr", i), 32'(power_enable), 32'(v.exp_pe));
            chk($sformatf("vec%0d_model_err", i), 32'(model_err), 32'd0);
            chk($sformatf("vec%0d_nack_err", i), 32'(nack_err), 32'd0);
        end

        // NACK on the height-high write while streaming aborts the sequence.
        @(negedge clk_in);
        base = log_q.size();
        exp_q.delete();
        add_wr(16'h0100, 8'h00);
        add_wr(16'h016C, 8'h07);
        add_wr(16'h016D, 8'h80);
        add_wr(16'h016E, 8'h04);
        nack_addr = 16'h016E;
        resolution = 2'd1;
        #1;
        chk("nack_ready_drop", 32'(ready), 32'd0);
        repeat (60) @(negedge clk_in);
        compare_log("nack", base);
        chk("nack_err_set", 32'(nack_err), 32'd1);
        chk("nack_pwr", 32'(power_enable), 32'd0);
        chk("nack_ready", 32'(ready), 32'd0);
        chk("nack_cmd_valid", 32'(cmd_valid), 32'd0);
        nack_addr = 16'hFFFF;
        mode = 2'd0;
        repeat (2) @(negedge clk_in);
        chk("nack_clear_ready", 32'(ready), 32'd1);
        chk("nack_clear_err", 32'(nack_err), 32'd0);

        // Input change during power wait is held off until the sequence is idle again.
        @(negedge clk_in);
        base = log_q.size();
        exp_q.delete();
        add_reads();
        add_cfg(16'h0280, 16'h01E0, 8'h08, 1'b0);
        add_cfg(16'h0CD0, 16'h09A0, 8'h08, 1'b0);
        mode = 2'd1; resolution = 2'd3; format = 1'b0;
        repeat (5) @(negedge clk_in);
        resolution = 2'd0;
        #1;
        chk("ignore_ready", 32'(ready), 32'd0);
        wait_ready(3000, "ignore");
        compare_log("ignore", base);
        mode = 2'd0;
        repeat (2) @(negedge clk_in);
        chk("ignore_off_ready", 32'(ready), 32'd1);
        chk("ignore_off_pwr", 32'(power_enable), 32'd0);

`ifdef CAMERA_ID_CHECK_EN
        @(negedge clk_in);
        base = log_q.size();
        exp_q.delete();
        add_reads();
        id_lo_val = 8'h20;
        mode = 2'd1;
        repeat (80) @(negedge clk_in);
        compare_log("id_bad", base);
        chk("id_bad_model_err", 32'(model_err), 32'd1);
        chk("id_bad_pwr", 32'(power_enable), 32'd0);
        chk("id_bad_ready", 32'(ready), 32'd0);
        id_lo_val = 8'h19;
        mode = 2'd0;
        repeat (2) @(negedge clk_in);
        chk("id_bad_clear_err", 32'(model_err), 32'd0);
        chk("id_bad_clear_ready", 32'(ready), 32'd1);
`endif

        // Reset while a command is being presented, followed by a stray done pulse.
        @(negedge clk_in);
        cmd_ready = 1'b0;
        mode = 2'd1; resolution = 2'd1; format = 1'b0;
        k = 0;
        while (!cmd_valid && k < 100) begin @(negedge clk_in); k++; end
        chk("stall_valid", 32'(cmd_valid), 32'd1);
        #2;
        reset_n = 1'b0;
        mode = 2'd0;
        #1;
        chk_reset_outputs("rst_mid");
        @(negedge clk_in);
        reset_n = 1'b1;
        cmd_ready = 1'b1;
        base = log_q.size();
        force_req = force_req + 1;
        repeat (6) @(negedge clk_in);
        chk("stray_done_ready", 32'(ready), 32'd1);
        chk("stray_done_valid", 32'(cmd_valid), 32'd0);
        chk("stray_done_pwr", 32'(power_enable), 32'd0);
        chk("stray_done_log", 32'(log_q.size() - base), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
